// File: rtl/my_bullet_pool.sv
// my_bullet_pool: frame-stepped pool of player bullets with spawn cooldown, enemy/enemy-bullet collision and hit score
// Ports:
//    clk, rst                   clock, asynchronous active-high reset
//    vs_neg_i                   one-cycle frame tick; all state advances only on it
//    shoot_i                    fire request level, sampled on the tick
//    plane_x_i, plane_y_i       player plane centre
//    enemy_x_i, enemy_y_i       enemy plane centre, enemy_alive_i gates its collision
//    eb_x_i, eb_y_i             enemy bullet centre, eb_valid_i gates its collision
//    bullet_x_o, bullet_y_o     packed slot centres, slot i at [i*COORD_W +: COORD_W]
//    bullet_valid_o             slot live flags
//    hit_count_o                saturating enemy-hit score
//    hit_pulse_o, eb_cancel_o   one-cycle event flags following a tick
module my_bullet_pool #(
   parameter int NUM_BULLETS   = 4,
   parameter int COORD_W       = 11,
   parameter int SPEED         = 6,
   parameter int COOLDOWN      = 8,
   parameter int PLANE_HALF_H  = 64,
   parameter int BULLET_HALF_W = 16,
   parameter int BULLET_HALF_H = 32,
   parameter int ENEMY_HALF_W  = 64,
   parameter int ENEMY_HALF_H  = 64,
   parameter int EB_HALF_W     = 9,
   parameter int EB_HALF_H     = 16,
   parameter int HIT_W         = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           vs_neg_i,
   input  logic                           shoot_i,
   input  logic [COORD_W-1:0]             plane_x_i,
   input  logic [COORD_W-1:0]             plane_y_i,
   input  logic [COORD_W-1:0]             enemy_x_i,
   input  logic [COORD_W-1:0]             enemy_y_i,
   input  logic                           enemy_alive_i,
   input  logic [COORD_W-1:0]             eb_x_i,
   input  logic [COORD_W-1:0]             eb_y_i,
   input  logic                           eb_valid_i,
   output logic [NUM_BULLETS*COORD_W-1:0] bullet_x_o,
   output logic [NUM_BULLETS*COORD_W-1:0] bullet_y_o,
   output logic [NUM_BULLETS-1:0]         bullet_valid_o,
   output logic [HIT_W-1:0]               hit_count_o,
   output logic                           hit_pulse_o,
   output logic                           eb_cancel_o
);
   localparam int DW  = COORD_W + 1;
   localparam int CDW = $clog2(COOLDOWN + 2);
   localparam int NW  = $clog2(NUM_BULLETS + 1);
   localparam int SW  = HIT_W + NW + 1;
   typedef logic [COORD_W-1:0] coord_t;
   coord_t                 bx_q [NUM_BULLETS];
   coord_t                 bx_d [NUM_BULLETS];
   coord_t                 by_q [NUM_BULLETS];
   coord_t                 by_d [NUM_BULLETS];
   logic [NUM_BULLETS-1:0] valid_q, valid_d;
   logic [NUM_BULLETS-1:0] hit_e, hit_b, top, cand, cancel_sel, retire, free, spawn_sel;
   logic [HIT_W-1:0]       hit_q, hit_d;
   logic [CDW-1:0]         cd_q, cd_d;
   logic [NW-1:0]          nhits;
   logic [SW-1:0]          sum;
   logic                   spawn_ok, hit_pulse_q, eb_cancel_q;

   function automatic logic [DW-1:0] absdiff(input coord_t a, input coord_t b);
      return (a > b) ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
   endfunction

   always_comb begin
      hit_e = '0;
      hit_b = '0;
      top   = '0;
      nhits = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         hit_e[i] = valid_q[i] && enemy_alive_i
                 && absdiff(bx_q[i], enemy_x_i) <= DW'(BULLET_HALF_W + ENEMY_HALF_W)
                 && absdiff(by_q[i], enemy_y_i) <= DW'(BULLET_HALF_H + ENEMY_HALF_H);
         hit_b[i] = valid_q[i] && eb_valid_i
                 && absdiff(bx_q[i], eb_x_i) <= DW'(BULLET_HALF_W + EB_HALF_W)
                 && absdiff(by_q[i], eb_y_i) <= DW'(BULLET_HALF_H + EB_HALF_H);
         top[i]   = valid_q[i] && by_q[i] <= coord_t'(SPEED + BULLET_HALF_H);
         nhits    = nhits + NW'(hit_e[i]);
      end
      // x & -x isolates the lowest set bit: one enemy bullet can absorb only one slot,
      // and free slots are filled lowest index first
      cand       = hit_b & ~hit_e;
      cancel_sel = cand & (~cand + NUM_BULLETS'(1));
      retire     = hit_e | cancel_sel | top;
      free       = ~valid_q;
      spawn_sel  = free & (~free + NUM_BULLETS'(1));
      spawn_ok   = shoot_i && cd_q == '0 && |free
                && plane_y_i >= coord_t'(PLANE_HALF_H + BULLET_HALF_H);
      for (int i = 0; i < NUM_BULLETS; i++) begin
         valid_d[i] = (valid_q[i] & ~retire[i]) | (spawn_ok & spawn_sel[i]);
         bx_d[i]    = (spawn_ok && spawn_sel[i]) ? plane_x_i : bx_q[i];
         by_d[i]    = (spawn_ok && spawn_sel[i]) ? plane_y_i - coord_t'(PLANE_HALF_H + BULLET_HALF_H)
                    : (valid_q[i] && !retire[i]) ? by_q[i] - coord_t'(SPEED) : by_q[i];
      end
      sum   = SW'(hit_q) + SW'(nhits);
      hit_d = (sum > SW'({HIT_W{1'b1}})) ? '1 : sum[HIT_W-1:0];
      cd_d  = spawn_ok ? CDW'(COOLDOWN) : (cd_q != '0) ? cd_q - CDW'(1) : cd_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         hit_q       <= '0;
         cd_q        <= '0;
         hit_pulse_q <= 1'b0;
         eb_cancel_q <= 1'b0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            bx_q[i] <= '0;
            by_q[i] <= '0;
         end
      end else begin
         hit_pulse_q <= vs_neg_i && nhits != '0;
         eb_cancel_q <= vs_neg_i && |cancel_sel;
         if (vs_neg_i) begin
            valid_q <= valid_d;
            hit_q   <= hit_d;
            cd_q    <= cd_d;
            for (int i = 0; i < NUM_BULLETS; i++) begin
               bx_q[i] <= bx_d[i];
               by_q[i] <= by_d[i];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
      assign bullet_x_o[g*COORD_W +: COORD_W] = bx_q[g];
      assign bullet_y_o[g*COORD_W +: COORD_W] = by_q[g];
   end

   assign bullet_valid_o = valid_q;
   assign hit_count_o    = hit_q;
   assign hit_pulse_o    = hit_pulse_q;
   assign eb_cancel_o    = eb_cancel_q;
endmodule

// File: tb/tb_my_bullet_pool.sv
// tb_my_bullet_pool: directed self-checking bench for my_bullet_pool with default parameters
module tb_my_bullet_pool;
   localparam int N  = 4;
   localparam int CW = 11;
   logic            clk = 0, rst = 1, vs_neg = 0, shoot = 0, enemy_alive = 0, eb_valid = 0;
   logic [CW-1:0]   plane_x = 320, plane_y = 400, enemy_x = 320, enemy_y = 100, eb_x = 0, eb_y = 0;
   logic [N*CW-1:0] bullet_x, bullet_y;
   logic [N-1:0]    bullet_valid;
   logic [3:0]      hit_count;
   logic            hit_pulse, eb_cancel;
   int              n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   my_bullet_pool dut (
      .clk(clk), .rst(rst), .vs_neg_i(vs_neg), .shoot_i(shoot),
      .plane_x_i(plane_x), .plane_y_i(plane_y),
      .enemy_x_i(enemy_x), .enemy_y_i(enemy_y), .enemy_alive_i(enemy_alive),
      .eb_x_i(eb_x), .eb_y_i(eb_y), .eb_valid_i(eb_valid),
      .bullet_x_o(bullet_x), .bullet_y_o(bullet_y), .bullet_valid_o(bullet_valid),
      .hit_count_o(hit_count), .hit_pulse_o(hit_pulse), .eb_cancel_o(eb_cancel)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sy(input int i);
      return 32'(bullet_y[i*CW +: CW]);
   endfunction

   function automatic logic [31:0] sx(input int i);
      return 32'(bullet_x[i*CW +: CW]);
   endfunction

   task automatic tick(input bit s = 0);
      @(negedge clk);
      shoot  = s;
      vs_neg = 1;
      @(negedge clk);
      vs_neg = 0;
      shoot  = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0);
   endtask

   task automatic do_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   // three bullets from (320,400) nine frames apart: slot0 y=196, slot1 y=250, slot2 y=304
   task automatic fill3;
      plane_x = 320;
      plane_y = 400;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         if (k < 2) idle(8);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst valid", 32'(bullet_valid), 0);
      check("rst y", 32'(|bullet_y), 0);
      check("rst hits", 32'(hit_count), 0);
      check("rst pulse", 32'(hit_pulse), 0);
      rst = 0;

      // single shot
      tick(1);
      check("single valid", 32'(bullet_valid), 1);
      check("single x0", sx(0), 320);
      check("single y0", sy(0), 304);
      idle(10);
      check("single y0 +10", sy(0), 244);
      check("single only one", 32'(bullet_valid), 1);
      repeat (3) @(negedge clk);
      check("hold between ticks", sy(0), 244);

      // hold shoot: spawns on 0, 9, 18, 27; drop while full; reuse slot0
      do_reset;
      plane_x = 320;
      plane_y = 400;
      for (int t = 0; t <= 47; t++) begin
         tick(1);
         if (t == 8)  check("fill t8", 32'(bullet_valid), 4'b0001);
         if (t == 9)  check("fill t9", 32'(bullet_valid), 4'b0011);
         if (t == 27) begin
            check("fill t27", 32'(bullet_valid), 4'b1111);
            check("fill y0", sy(0), 142);
            check("fill y1", sy(1), 196);
            check("fill y2", sy(2), 250);
            check("fill y3", sy(3), 304);
         end
         if (t == 45) check("fill t45 y0", sy(0), 34);
         if (t == 46) begin
            check("retire t46", 32'(bullet_valid), 4'b1110);
            check("retire y0 hold", sy(0), 34);
         end
         if (t == 47) begin
            check("reuse valid", 32'(bullet_valid), 4'b1111);
            check("reuse y0", sy(0), 304);
            check("reuse y1", sy(1), 76);
            check("reuse y3", sy(3), 184);
         end
      end

      // top exit boundary
      do_reset;
      plane_y = 134;
      tick(1);
      check("top38 spawn", sy(0), 38);
      tick();
      check("top38 retired", 32'(bullet_valid), 0);
      check("top38 y hold", sy(0), 38);
      do_reset;
      plane_y = 135;
      tick(1);
      check("top39 spawn", sy(0), 39);
      tick();
      check("top39 move", sy(0), 33);
      check("top39 live", 32'(bullet_valid), 1);
      tick();
      check("top39 retired", 32'(bullet_valid), 0);
      check("top hits", 32'(hit_count), 0);

      // plane too high: rejected without loading the cooldown
      do_reset;
      plane_y = 95;
      tick(1);
      check("high reject", 32'(bullet_valid), 0);
      plane_y = 400;
      tick(1);
      check("after reject", 32'(bullet_valid), 1);

      // double hit on enemy at (320,100)
      do_reset;
      plane_x = 320;
      plane_y = 300;
      tick(1);
      idle(8);
      plane_x = 300;
      plane_y = 246;
      tick(1);
      check("dbl setup y0", sy(0), 150);
      check("dbl setup y1", sy(1), 150);
      check("dbl setup x1", sx(1), 300);
      tick();
      check("dead enemy valid", 32'(bullet_valid), 4'b0011);
      check("dead enemy hits", 32'(hit_count), 0);
      check("dead enemy pulse", 32'(hit_pulse), 0);
      check("dead enemy y1", sy(1), 144);
      enemy_alive = 1;
      tick();
      enemy_alive = 0;
      check("dbl valid", 32'(bullet_valid), 0);
      check("dbl hits", 32'(hit_count), 2);
      check("dbl pulse", 32'(hit_pulse), 1);
      @(negedge clk);
      check("dbl pulse drop", 32'(hit_pulse), 0);

      // triple-hit rounds up to 14, then saturate
      idle(8);
      enemy_x = 320;
      enemy_y = 250;
      for (int r = 0; r < 5; r++) begin
         fill3;
         enemy_alive = 1;
         tick();
         enemy_alive = 0;
         check("round hits", 32'(hit_count), (r == 4) ? 15 : 5 + 3 * r);
         if (r == 4) check("sat pulse", 32'(hit_pulse), 1);
         idle(8);
      end

      // enemy bullet cancel: only the lowest overlapping slot
      do_reset;
      fill3;
      eb_x     = 320;
      eb_y     = 277;
      eb_valid = 1;
      tick();
      eb_valid = 0;
      check("cancel valid", 32'(bullet_valid), 4'b0101);
      check("cancel flag", 32'(eb_cancel), 1);
      check("cancel y2", sy(2), 298);
      check("cancel hits", 32'(hit_count), 0);
      @(negedge clk);
      check("cancel drop", 32'(eb_cancel), 0);

      // slot1 hits the enemy, so slot2 takes the cancel
      do_reset;
      fill3;
      enemy_x     = 320;
      enemy_y     = 160;
      enemy_alive = 1;
      eb_valid    = 1;
      tick();
      enemy_alive = 0;
      eb_valid    = 0;
      check("mix valid", 32'(bullet_valid), 0);
      check("mix hits", 32'(hit_count), 2);
      check("mix cancel", 32'(eb_cancel), 1);
      check("mix pulse", 32'(hit_pulse), 1);

      // asynchronous reset mid-run with live bullets and cooldown 5
      idle(8);
      fill3;
      idle(3);
      check("pre-rst valid", 32'(bullet_valid), 4'b0111);
      @(negedge clk);
      #2 rst = 1;
      #1;
      check("async rst valid", 32'(bullet_valid), 0);
      check("async rst y", 32'(|bullet_y), 0);
      check("async rst hits", 32'(hit_count), 0);
      #1 rst = 0;
      plane_y = 400;
      tick(1);
      check("post-rst spawn", 32'(bullet_valid), 1);
      check("post-rst y0", sy(0), 304);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/my_bullet_pool.md
# my_bullet_pool

Frame-synchronous controller for up to NUM_BULLETS simultaneous player bullets, the parametrised successor of the single-bullet player controller. It spawns bullets above the player plane with a cooldown, and advances all live bullets once per video frame. Each bullet is checked against the enemy plane and the enemy bullet, and the block keeps a saturating hit score. It sits between the input/plane-position logic and the VGA sprite renderer and game-state logic, driven by the same `vs_neg` frame tick.

## Interface
Parameters:
- `NUM_BULLETS`, 4: bullet slots (1..8).
- `COORD_W`, 11: coordinate width (centre coordinates).
- `SPEED`, 6: upward pixels per frame.
- `COOLDOWN`, 8: frames between accepted shots.
- `PLANE_HALF_H`, 64: player plane half-height.
- `BULLET_HALF_W` / `BULLET_HALF_H`, 16 / 32: player bullet half-size.
- `ENEMY_HALF_W` / `ENEMY_HALF_H`, 64 / 64: enemy plane half-size.
- `EB_HALF_W` / `EB_HALF_H`, 9 / 16: enemy bullet half-size.
- `HIT_W`, 4: score width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vs_neg`  in  1  one-`clk` frame tick; all state updates only on this cycle.
- `shoot`  in  1  fire request level, sampled on `vs_neg`.
- `plane_x`, `plane_y`  in  COORD_W  player plane centre.
- `enemy_x`, `enemy_y`  in  COORD_W  enemy plane centre.
- `enemy_alive`  in  1  gates enemy collision.
- `eb_x`, `eb_y`  in  COORD_W  enemy bullet centre.
- `eb_valid`  in  1  gates enemy-bullet collision.
- `bullet_x`, `bullet_y`  out  NUM_BULLETS*COORD_W  packed centres; slot i at [i*COORD_W +: COORD_W].
- `bullet_valid`  out  NUM_BULLETS  slot live flags.
- `hit_count`  out  HIT_W  saturating enemy-hit score.
- `hit_pulse`  out  1  high one `clk` after a frame with ≥1 enemy hit.
- `eb_cancel`  out  1  high one `clk` after a frame in which a bullet destroyed the enemy bullet.

## Operation
- Reset values: `bullet_valid` = 0, all coordinates 0, `hit_count` = 0, `hit_pulse` = 0, `eb_cancel` = 0, cooldown counter = 0.
- Per `vs_neg`, each live slot is evaluated on its current (pre-move) position, in this priority order:
  1. **Enemy hit:** `enemy_alive`, |bx−enemy_x| ≤ BULLET_HALF_W+ENEMY_HALF_W and |by−enemy_y| ≤ BULLET_HALF_H+ENEMY_HALF_H. The slot is retired.
  2. **Enemy-bullet cancel:** `eb_valid` and the overlap test with EB_HALF_W/EB_HALF_H. Only the lowest-index qualifying slot (not already retired by rule 1) is retired and asserts `eb_cancel`.
  3. **Top boundary:** by ≤ SPEED+BULLET_HALF_H. The slot is retired.
  4. **Otherwise:** by ← by−SPEED, bx unchanged.
- Absolute differences are computed at COORD_W+1 bits with no wraparound.
- Retiring a slot clears its valid bit. Coordinates of dead slots hold their last value.
- `hit_count` += number of slots retired by rule 1 in that frame, saturating at 2^HIT_W−1. `hit_pulse` is set if that number is ≥1.
- **Cooldown counter:** decrements by 1 per `vs_neg` while nonzero.
- **Spawn:** on `vs_neg`, if `shoot`=1, cooldown=0, at least one slot was dead at frame start, and plane_y ≥ PLANE_HALF_H+BULLET_HALF_H:
  - the lowest-index dead slot loads (plane_x, plane_y−PLANE_HALF_H−BULLET_HALF_H) and becomes valid;
  - cooldown loads COOLDOWN.
- A slot retired in the current frame is not reusable until the next frame.
- A spawned bullet is not moved or collision-checked in its spawn frame.
- A rejected shot (no free slot, or plane too high) does not load the cooldown.
- Between ticks all outputs hold. The `shoot` level has no edge detection; holding it fires every COOLDOWN+1 frames.

## Timing
- All outputs are registered and update on the `clk` edge of the `vs_neg` cycle, i.e. visible one cycle after `vs_neg` is sampled high.
- `hit_pulse` and `eb_cancel` are high for exactly that one cycle.
- Inputs need only be stable in the `vs_neg` cycle.
- Back-to-back `vs_neg` on consecutive cycles is legal; each tick is one full frame step.
- `rst` asserted mid-frame clears everything immediately (asynchronous). The first `vs_neg` after deassertion behaves as a normal frame with cooldown=0.

## Test plan
- **Single shot:** plane=(320,400), `shoot` for one tick → slot0 valid at (320,304). After 10 further ticks y=244. Nothing else spawns.
- **Hold and fill:** hold `shoot` with NUM_BULLETS=4, COOLDOWN=8 → spawns on ticks 0, 9, 18, 27 into slots 0-3.
  - Once slot0 retires, the next spawn reuses slot0.
  - With all slots full, a shot is dropped and the cooldown stays 0.
- **Top exit:** bullet at y=38 → retired on the next tick. A bullet at y=39 moves to 33, then retires on the following tick. `hit_count` is unchanged.
- **Double hit:** two bullets overlapping the enemy at (320,100), `enemy_alive`=1 → both retired, `hit_count`+2, `hit_pulse` one cycle.
  - With `enemy_alive`=0 → no hit.
  - At `hit_count`=14 with three hits → saturates at 15.
- **Enemy-bullet cancel:** slots 1 and 2 both overlap the enemy bullet, which does not overlap the enemy plane → only slot1 retired, `eb_cancel` one cycle.
  - If slot1 also hits the enemy, slot1 counts as a hit and slot2 cancels the enemy bullet.
- **Reset mid-run:** `rst` pulse between ticks with 3 live bullets and cooldown=5 → all outputs 0 immediately. The next tick with `shoot` spawns into slot0.
